// File: rtl/crc32_fcs_append_pkg.sv
// Shared CRC-32 definitions for the FCS append block and any future checker rework.
//   CRC_POLY / CRC_INIT / CRC_MAGIC_NUMBER : reflected CRC-32 constants
//   state_t and S_* : FSM encodings for the append block
//   crc32_byte()    : one-byte LSB-first CRC-32 update
package crc32_fcs_append_pkg;

  localparam logic [31:0] CRC_POLY         = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT         = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_MAGIC_NUMBER = 32'hDEBB20E3;

  typedef logic [1:0] state_t;

  localparam state_t S_DATA = 2'd0;
  localparam state_t S_PAD  = 2'd1;
  localparam state_t S_FCS  = 2'd2;

  // Bitwise reflected CRC-32 update, one data bit per iteration (LSB first).
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_fcs_append_if.sv
// Byte-stream bundle around the FCS append block.
//   in_d/in_v/in_last/in_rdy     : payload stream from the frame builder
//   out_d/out_v/out_last/out_rdy : framed stream towards the MAC/PHY
//   slave  : the append block
//   master : the surrounding logic (frame builder + sink)
interface crc32_fcs_append_if;
  logic [7:0] in_d;
  logic       in_v;
  logic       in_last;
  logic       in_rdy;
  logic [7:0] out_d;
  logic       out_v;
  logic       out_last;
  logic       out_rdy;

  modport slave (
    input  in_d, in_v, in_last, out_rdy,
    output in_rdy, out_d, out_v, out_last
  );

  modport master (
    output in_d, in_v, in_last, out_rdy,
    input  in_rdy, out_d, out_v, out_last
  );
endinterface

// File: rtl/crc32_fcs_append.sv
// Transmit-side CRC-32 FCS append: passes payload through, optionally zero-pads
// short frames to MIN_LEN bytes, then appends the 4-byte FCS LSB first.
//   clk : clock
//   rst : synchronous active-high reset (aborts any frame in flight)
//   bus : crc32_fcs_append_if.slave byte-stream in/out with valid/ready
// Output is one register stage; in_rdy is combinational from that stage.
module crc32_fcs_append
  import crc32_fcs_append_pkg::*;
#(
  parameter int unsigned PAD_EN  = 1,
  parameter int unsigned MIN_LEN = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  crc32_fcs_append_if.slave     bus
);

  localparam int unsigned CNT_W = $clog2(MIN_LEN + 1);

  state_t            r_state;
  logic [31:0]       r_crc;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_idx;
  logic [7:0]        r_out_d;
  logic              r_out_v;
  logic              r_out_last;

  state_t            w_state_n;
  logic [31:0]       w_crc_n;
  logic [CNT_W-1:0]  w_cnt_n;
  logic [1:0]        w_idx_n;
  logic [7:0]        w_out_d_n;
  logic              w_out_v_n;
  logic              w_out_last_n;

  logic              w_adv;
  logic              w_in_rdy;
  logic              w_xfer;
  logic [CNT_W:0]    w_cnt_inc;
  logic [CNT_W-1:0]  w_cnt_sat;
  logic [31:0]       w_fcs;
  logic [7:0]        w_fcs_byte;

  // Output stage can take a new byte when empty or being drained this cycle.
  assign w_adv     = !r_out_v | bus.out_rdy;
  assign w_in_rdy  = (r_state == S_DATA) & w_adv & !rst;
  assign w_xfer    = bus.in_v & w_in_rdy;

  // One extra bit so cnt+1 never wraps before the MIN_LEN comparisons.
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W + 1)'(1);
  assign w_cnt_sat = (w_cnt_inc <= (CNT_W + 1)'(MIN_LEN)) ? w_cnt_inc[CNT_W-1:0] : r_cnt;

  assign w_fcs = ~r_crc;

  // FCS byte select, least significant byte first.
  always_comb begin
    w_fcs_byte = w_fcs[7:0];
    case (r_idx)
      2'd0:    w_fcs_byte = w_fcs[7:0];
      2'd1:    w_fcs_byte = w_fcs[15:8];
      2'd2:    w_fcs_byte = w_fcs[23:16];
      default: w_fcs_byte = w_fcs[31:24];
    endcase
  end

  // Next-state and output-register load logic; nothing moves without w_adv.
  always_comb begin
    w_state_n    = r_state;
    w_crc_n      = r_crc;
    w_cnt_n      = r_cnt;
    w_idx_n      = r_idx;
    w_out_d_n    = r_out_d;
    w_out_v_n    = r_out_v;
    w_out_last_n = r_out_last;

    case (r_state)
      S_DATA: begin
        if (w_xfer) begin
          w_out_d_n    = bus.in_d;
          w_out_v_n    = 1'b1;
          w_out_last_n = 1'b0;
          w_crc_n      = crc32_byte(r_crc, bus.in_d);
          w_cnt_n      = w_cnt_sat;
          if (bus.in_last) begin
            if ((PAD_EN != 0) && (w_cnt_inc < (CNT_W + 1)'(MIN_LEN))) w_state_n = S_PAD;
            else                                                      w_state_n = S_FCS;
          end
        end else if (w_adv) begin
          // Sink drained the stage and no new byte arrived: bubble.
          w_out_v_n    = 1'b0;
          w_out_last_n = 1'b0;
        end
      end

      S_PAD: begin
        if (w_adv) begin
          w_out_d_n    = 8'h00;
          w_out_v_n    = 1'b1;
          w_out_last_n = 1'b0;
          w_crc_n      = crc32_byte(r_crc, 8'h00);
          w_cnt_n      = w_cnt_sat;
          if (w_cnt_inc >= (CNT_W + 1)'(MIN_LEN)) w_state_n = S_FCS;
        end
      end

      S_FCS: begin
        if (w_adv) begin
          w_out_d_n    = w_fcs_byte;
          w_out_v_n    = 1'b1;
          w_out_last_n = (r_idx == 2'd3);
          if (r_idx == 2'd3) begin
            w_state_n = S_DATA;
            w_crc_n   = CRC_INIT;
            w_cnt_n   = '0;
            w_idx_n   = 2'd0;
          end else begin
            w_idx_n   = r_idx + 2'd1;
          end
        end
      end

      default: begin
        w_state_n = S_DATA;
      end
    endcase
  end

  // State, CRC and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_DATA;
      r_crc      <= CRC_INIT;
      r_cnt      <= '0;
      r_idx      <= 2'd0;
      r_out_d    <= 8'h00;
      r_out_v    <= 1'b0;
      r_out_last <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_crc      <= w_crc_n;
      r_cnt      <= w_cnt_n;
      r_idx      <= w_idx_n;
      r_out_d    <= w_out_d_n;
      r_out_v    <= w_out_v_n;
      r_out_last <= w_out_last_n;
    end
  end

  assign bus.in_rdy   = w_in_rdy;
  assign bus.out_d    = r_out_d;
  assign bus.out_v    = r_out_v;
  assign bus.out_last = r_out_last;

endmodule
